shift_add_multiplier: RTL
=========================

Name: shift_add_multiplier

Overview:
- Sequential 4x4 unsigned multiplier producing an 8-bit product by shift-and-add.
- Sits directly downstream of the existing ripple_adder: one ripple_adder instance does every partial-product add; this block supplies its operands each cycle and consumes its s0..s3/cout.
- Start/busy/done handshake so a controller can issue one multiply at a time.

Parameters:
- WIDTH, 4, operand width; fixed at 4 because ripple_adder is 4-bit; any other value is unsupported.
- ITERS, 4, add/shift iterations per multiply; must equal WIDTH.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  4  multiplicand, captured when start is accepted
- b  input  4  multiplier, captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the product is written
- product  output  8  last completed product; held until the next completion

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, product=8'h00; internal regs M, Q, A, C and cnt cleared. Reset in any state, including mid-RUN, aborts the operation with no done pulse, and product returns to 0.
- Registers:
  - M[3:0] holds the multiplicand.
  - Q[3:0] holds the multiplier and receives the low product bits.
  - A[3:0] is the accumulator.
  - C is the carry bit.
  - cnt[2:0] counts iterations.
- ripple_adder hookup: a0..a3=A, b0..b3=M, cin0=0; s0..s3 and cout feed the RUN update. The adder is purely combinational; this block adds no pipeline stage.
- IDLE:
  - busy=0, done=0.
  - If start=1 at the edge: M<=a, Q<=b, A<=0, C<=0, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - If Q[0]=1: {C,A} = {cout, s3..s0}. Otherwise {C,A} = {0,A}.
  - At the edge: {C,A,Q} <= {0, C_sel, A_sel, Q[3:1]}, i.e. the 9-bit value is shifted right by 1.
  - cnt<=cnt+1. When cnt==ITERS-1, go to DONE and write product <= {A_next,Q_next}.
  - start is ignored; busy=1.
- DONE: done=1 for exactly this one cycle, busy=0. Unconditionally return to IDLE next edge; start in DONE is ignored (a new request must be presented in IDLE).
- Latency: start high in cycle 0 (accepted at edge 1); RUN in cycles 1-4; done=1 and product valid in cycle 5; IDLE in cycle 6. Earliest next accept is at edge 7. Throughput is 1 multiply per 6 cycles.
- Arithmetic: unsigned. The add width is 4+carry, and the final product always fits 8 bits (max 15*15=225), so no overflow.
- a/b changes after acceptance have no effect on the running operation.
- The product register only changes on DONE entry or reset.

Decomposition:
- Shared package mult_pkg:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - WIDTH=4, ITERS=4, PROD_W=8
- One sub-module: the existing ripple_adder, instantiated once. It is reused unchanged with per-bit ports (a0..a3, b0..b3, cin0, s0..s3, cout).
- FSM, counter and shift register stay in shift_add_multiplier.

Test Plan:
- Reset, then a=3, b=5, start pulse in cycle 0 -> busy=1 in cycles 1-4; done=1 only in cycle 5 with product=8'h0F; IDLE in cycle 6.
- a=15, b=15 -> product=8'hE1 (225). a=9, b=1 -> 8'h09. a=0, b=13 -> 8'h00. Each case: exactly one done pulse, 5 cycles after start.
- Start held high continuously with a=2, b=7 -> product 8'h0E; next accept at edge 7; done pulses every 6 cycles. Operand changes to a=4, b=4 during RUN do not alter that result; the next result is 8'h10.
- Complete a=6, b=6 (product 8'h24), then issue a=5, b=3; assert rst in cycle 2 of that RUN -> next cycle busy=0, done=0, product=8'h00, state IDLE, and no done pulse follows.
- Exhaustive sweep of all 256 (a,b) pairs, back-to-back -> every product == a*b, and busy and done are never high together.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: operand/product widths,
// iteration count and FSM state encoding.
package mult_pkg;

  localparam int WIDTH  = 4;
  localparam int ITERS  = 4;
  localparam int PROD_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/ripple_adder.sv
// 4-bit ripple-carry adder with per-bit ports; purely combinational.
module ripple_adder (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic cin0,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic cout
);

  logic c1, c2, c3;

  assign s0   = a0 ^ b0 ^ cin0;
  assign c1   = (a0 & b0) | (a0 & cin0) | (b0 & cin0);
  assign s1   = a1 ^ b1 ^ c1;
  assign c2   = (a1 & b1) | (a1 & c1) | (b1 & c1);
  assign s2   = a2 ^ b2 ^ c2;
  assign c3   = (a2 & b2) | (a2 & c2) | (b2 & c2);
  assign s3   = a3 ^ b3 ^ c3;
  assign cout = (a3 & b3) | (a3 & c3) | (b3 & c3);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier with start/busy/done
// handshake; every partial-product add goes through one ripple_adder.
module shift_add_multiplier #(
  parameter int WIDTH = mult_pkg::WIDTH,  // only 4 is supported (adder is 4-bit)
  parameter int ITERS = mult_pkg::ITERS   // must equal WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic                        busy,
  output logic                        done,
  output logic [mult_pkg::PROD_W-1:0] product,
  output logic [1:0]                  state_dbg
);

  // Handshake: start is only sampled in IDLE; busy is high for the ITERS
  // RUN cycles; done is a single-cycle pulse in DONE, when product updates.

  logic [1:0]                  state_q, state_d;
  logic [WIDTH-1:0]            m_q, m_d;
  logic [WIDTH-1:0]            q_q, q_d;
  logic [WIDTH-1:0]            a_q, a_d;
  logic                        c_q, c_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic [mult_pkg::PROD_W-1:0] product_q, product_d;

  logic       s0, s1, s2, s3, cout;
  logic [4:0] sum_sel;

  ripple_adder u_adder (
    .a0   (a_q[0]),
    .a1   (a_q[1]),
    .a2   (a_q[2]),
    .a3   (a_q[3]),
    .b0   (m_q[0]),
    .b1   (m_q[1]),
    .b2   (m_q[2]),
    .b3   (m_q[3]),
    .cin0 (1'b0),
    .s0   (s0),
    .s1   (s1),
    .s2   (s2),
    .s3   (s3),
    .cout (cout)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    a_d       = a_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    // C is zero on entry to every iteration, so the no-add path is {C,A}.
    sum_sel   = q_q[0] ? {cout, s3, s2, s1, s0} : {c_q, a_q};

    case (state_q)
      mult_pkg::IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = mult_pkg::RUN;
        end
      end
      mult_pkg::RUN: begin
        c_d   = 1'b0;
        a_d   = sum_sel[4:1];
        q_d   = {sum_sel[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(ITERS - 1)) begin
          state_d   = mult_pkg::DONE;
          product_d = {sum_sel[4:1], sum_sel[0], q_q[WIDTH-1:1]};
        end
      end
      mult_pkg::DONE: begin
        state_d = mult_pkg::IDLE;
      end
      default: begin
        state_d = mult_pkg::IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= mult_pkg::IDLE;
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      a_q       <= a_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy      = (state_q == mult_pkg::RUN);
  assign done      = (state_q == mult_pkg::DONE);
  assign product   = product_q;
  assign state_dbg = state_q;

endmodule
